// File: rtl/imem_boot.sv
// Instruction memory with a byte-stream boot loader: fetch result one cycle after fetch_req.
// Loader takes bytes on ld_valid & ld_ready; while a load is in progress fetches return NOP/invalid.
module imem_boot #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    input  logic              ld_start,
    input  logic [7:0]        ld_byte,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              busy,
    output logic              ld_done,
    output logic              ld_err
);

    localparam int NB = DATA_W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              done_nxt;
    logic [15:0]       cnt;
    logic [15:0]       w;
    logic [BW-1:0]     b;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] word_asm;
    logic              accept;
    logic              last_byte;
    logic              last_word;
    logic              word_done;
    logic              w_in_range;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    assign busy       = (state != IDLE);
    assign ld_ready   = busy;
    assign accept     = ld_valid & ld_ready;
    assign last_byte  = (b == BW'(NB - 1));
    assign last_word  = (w == cnt - 16'd1);
    assign word_done  = (state == DATA) & accept & last_byte;
    // Words past the end of memory are still consumed from the stream, just not stored.
    assign w_in_range = ((w >> ADDR_W) == 16'd0);

    generate
        if (NB == 1) begin : g_nb1
            assign word_asm = ld_byte;
        end else begin : g_nbn
            assign word_asm = {shreg[DATA_W-9:0], ld_byte};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) state_nxt = CNT_HI;
            end
            CNT_HI: begin
                if (accept) state_nxt = CNT_LO;
            end
            CNT_LO: begin
                if (accept) begin
                    if ({cnt[15:8], ld_byte} == 16'd0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (word_done && last_word) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ld_done <= 1'b0;
            ld_err  <= 1'b0;
            cnt     <= 16'd0;
            w       <= 16'd0;
            b       <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            ld_done <= done_nxt;
            if (state == IDLE && ld_start) begin
                ld_err <= 1'b0;
                w      <= 16'd0;
                b      <= '0;
            end
            if (state == CNT_HI && accept) cnt[15:8] <= ld_byte;
            if (state == CNT_LO && accept) cnt[7:0]  <= ld_byte;
            if (state == DATA && accept) begin
                shreg <= word_asm;
                if (last_byte) begin
                    b <= '0;
                    w <= w + 16'd1;
                    if (!w_in_range) ld_err <= 1'b1;
                end else begin
                    b <= b + 1'b1;
                end
            end
        end
    end

    // Contents survive rst; only the write of an interrupted load's current word is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && word_done && w_in_range) mem[w[ADDR_W-1:0]] <= word_asm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (busy) begin
            out_valid <= 1'b0;
            if (fetch_req) out <= '0;
        end else if (fetch_req) begin
            out       <= mem[address];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
